// File: rtl/output_buffer_ctrl.sv
// Double-buffered PSOLA output BRAM sequencer: steers writes to the idle bank, paces reads per tick.
// Optional build macro OUTBUF_REPEAT_EN: replay the playing bank instead of muting on underrun.
module output_buffer_ctrl #(
  parameter int MAX_EXTENDED = 2200,
  parameter int RD_LATENCY   = 2,
  parameter int CNT_W        = 16,
  localparam int AW = $clog2(2 * MAX_EXTENDED),
  localparam int LW = $clog2(MAX_EXTENDED + 1),
  localparam int IW = $clog2(MAX_EXTENDED)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             wr_valid_in,
  input  logic [IW-1:0]    wr_addr_in,
  input  logic             wr_done_in,
  input  logic [LW-1:0]    wr_len_in,
  output logic             wr_ready_out,
  input  logic             tick_in,
  output logic [AW-1:0]    bram_wr_addr_out,
  output logic             bram_we_out,
  output logic [AW-1:0]    bram_rd_addr_out,
  output logic             rd_valid_out,
  output logic             mute_out,
  output logic             play_bank_out,
  output logic [CNT_W-1:0] underrun_count_out,
  output logic [CNT_W-1:0] overrun_count_out
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PLAY     = 2'd1,
    ST_UNDERRUN = 2'd2
  } state_t;

  localparam logic [AW-1:0] BANK1_BASE = AW'(MAX_EXTENDED);
  localparam logic [LW-1:0] LEN_MAX    = LW'(MAX_EXTENDED);
  localparam logic [LW-1:0] LEN_ONE    = {{(LW-1){1'b0}}, 1'b1};

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
    clamp_len = (len > LEN_MAX) ? LEN_MAX : len;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
    if (inc && (cnt != {CNT_W{1'b1}})) begin
      sat_inc = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      sat_inc = cnt;
    end
  endfunction

  state_t            r_state;
  logic              r_play_bank;
  logic [LW-1:0]     r_play_len;
  logic [LW-1:0]     r_rd_idx;
  logic              r_pending;
  logic [LW-1:0]     r_pend_len;
  logic [AW-1:0]     r_wr_addr;
  logic              r_we;
  logic [AW-1:0]     r_rd_addr;
  logic [RD_LATENCY:0] r_vld_pipe;
  logic              r_mute;
  logic              r_wr_ready;
  logic [CNT_W-1:0]  r_underrun_cnt;
  logic [CNT_W-1:0]  r_overrun_cnt;

  state_t            w_state_nxt;
  logic              w_bank_nxt;
  logic [LW-1:0]     w_play_len_nxt;
  logic [LW-1:0]     w_rd_idx_nxt;
  logic              w_pending_nxt;
  logic [LW-1:0]     w_pend_len_nxt;
  logic              w_issue;
  logic              w_ur_inc;
  logic              w_swap;
  logic              w_done_ok;
  logic              w_pend_any;
  logic [LW-1:0]     w_pend_len_eff;
  logic              w_last_idx;
  logic [AW-1:0]     w_rd_base;

  // Pending-frame view including a done pulse arriving this very cycle.
  always_comb begin
    w_done_ok      = wr_done_in && (wr_len_in != {LW{1'b0}});
    w_pend_any     = r_pending || w_done_ok;
    w_pend_len_eff = w_done_ok ? clamp_len(wr_len_in) : r_pend_len;
    w_last_idx     = (r_rd_idx == (r_play_len - LEN_ONE));
    w_rd_base      = r_play_bank ? BANK1_BASE : {AW{1'b0}};
  end

  // Next-state and datapath decisions for the playback FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_rd_idx_nxt   = r_rd_idx;
    w_issue        = 1'b0;
    w_ur_inc       = 1'b0;
    w_swap         = 1'b0;
    case (r_state)
      ST_IDLE, ST_UNDERRUN: begin
        if (w_pend_any) begin
          w_swap      = 1'b1;
          w_state_nxt = ST_PLAY;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_PLAY: begin
        if (tick_in) begin
          w_issue = 1'b1;
          if (!w_last_idx) begin
            w_rd_idx_nxt = r_rd_idx + LEN_ONE;
          end else if (w_pend_any) begin
            w_swap = 1'b1;
          end else begin
            w_ur_inc     = 1'b1;
            w_rd_idx_nxt = {LW{1'b0}};
`ifdef OUTBUF_REPEAT_EN
            w_state_nxt  = ST_PLAY;
`else
            w_state_nxt  = ST_UNDERRUN;
`endif
          end
        end else begin
          w_issue = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A swap consumes the pending frame, including one completing this cycle.
    if (w_swap) begin
      w_bank_nxt     = ~r_play_bank;
      w_play_len_nxt = w_pend_len_eff;
      w_rd_idx_nxt   = {LW{1'b0}};
      w_pending_nxt  = 1'b0;
      w_pend_len_nxt = w_pend_len_eff;
    end else begin
      w_bank_nxt     = r_play_bank;
      w_play_len_nxt = r_play_len;
      w_pending_nxt  = w_pend_any;
      w_pend_len_nxt = w_pend_len_eff;
    end
  end

  // State, address pipelines and event counters.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state        <= ST_IDLE;
      r_play_bank    <= 1'b1;
      r_play_len     <= {LW{1'b0}};
      r_rd_idx       <= {LW{1'b0}};
      r_pending      <= 1'b0;
      r_pend_len     <= {LW{1'b0}};
      r_wr_addr      <= {AW{1'b0}};
      r_we           <= 1'b0;
      r_rd_addr      <= {AW{1'b0}};
      r_vld_pipe     <= {(RD_LATENCY+1){1'b0}};
      r_mute         <= 1'b1;
      r_wr_ready     <= 1'b1;
      r_underrun_cnt <= {CNT_W{1'b0}};
      r_overrun_cnt  <= {CNT_W{1'b0}};
    end else begin
      r_state        <= w_state_nxt;
      r_play_bank    <= w_bank_nxt;
      r_play_len     <= w_play_len_nxt;
      r_rd_idx       <= w_rd_idx_nxt;
      r_pending      <= w_pending_nxt;
      r_pend_len     <= w_pend_len_nxt;
      // Writes use the pre-swap bank: the opposite of the bank playing now.
      r_wr_addr      <= AW'(wr_addr_in) + (r_play_bank ? {AW{1'b0}} : BANK1_BASE);
      r_we           <= wr_valid_in;
      r_rd_addr      <= w_issue ? (w_rd_base + AW'(r_rd_idx)) : r_rd_addr;
      r_vld_pipe     <= {r_vld_pipe[RD_LATENCY-1:0], w_issue};
      r_mute         <= (w_state_nxt != ST_PLAY);
      r_wr_ready     <= ~w_pending_nxt;
      r_underrun_cnt <= sat_inc(r_underrun_cnt, w_ur_inc);
      r_overrun_cnt  <= sat_inc(r_overrun_cnt, w_done_ok && r_pending);
    end
  end

  assign wr_ready_out       = r_wr_ready;
  assign bram_wr_addr_out   = r_wr_addr;
  assign bram_we_out        = r_we;
  assign bram_rd_addr_out   = r_rd_addr;
  assign rd_valid_out       = r_vld_pipe[RD_LATENCY];
  assign mute_out           = r_mute;
  assign play_bank_out      = r_play_bank;
  assign underrun_count_out = r_underrun_cnt;
  assign overrun_count_out  = r_overrun_cnt;

endmodule

// File: tb/tb_output_buffer_ctrl.sv
// Directed bench for output_buffer_ctrl: cycle table plus hand-written overrun/swap/repeat sequences.
module tb_output_buffer_ctrl;

  localparam int AW = 13;
  localparam int LW = 12;
  localparam int IW = 12;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          wr_valid_in = 1'b0;
  logic [IW-1:0] wr_addr_in = '0;
  logic          wr_done_in = 1'b0;
  logic [LW-1:0] wr_len_in = '0;
  logic          tick_in = 1'b0;
  logic          wr_ready_out, bram_we_out, rd_valid_out, mute_out, play_bank_out;
  logic [AW-1:0] bram_wr_addr_out, bram_rd_addr_out;
  logic [15:0]   underrun_count_out, overrun_count_out;

  int n_tests = 0;
  int n_fail  = 0;

  output_buffer_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .wr_valid_in(wr_valid_in), .wr_addr_in(wr_addr_in),
    .wr_done_in(wr_done_in), .wr_len_in(wr_len_in),
    .wr_ready_out(wr_ready_out), .tick_in(tick_in),
    .bram_wr_addr_out(bram_wr_addr_out), .bram_we_out(bram_we_out),
    .bram_rd_addr_out(bram_rd_addr_out), .rd_valid_out(rd_valid_out),
    .mute_out(mute_out), .play_bank_out(play_bank_out),
    .underrun_count_out(underrun_count_out), .overrun_count_out(overrun_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        wv; int wa; logic done; int len; logic tick;
    logic        bank; logic mute; logic ready; logic we;
    int          wao; int rao; logic rv; int ur; int ovr;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic wv, input int wa, input logic done, input int len,
                              input logic tick, input logic bank, input logic mute,
                              input logic we, input int wao, input int rao, input logic rv,
                              input int ur);
    vec_t v;
    v.wv = wv; v.wa = wa; v.done = done; v.len = len; v.tick = tick;
    v.bank = bank; v.mute = mute; v.ready = 1'b1; v.we = we;
    v.wao = wao; v.rao = rao; v.rv = rv; v.ur = ur; v.ovr = 0;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic wv, input int wa, input logic done, input int len, input logic tick);
    @(negedge clk_in);
    wr_valid_in = wv;
    wr_addr_in  = IW'(wa);
    wr_done_in  = done;
    wr_len_in   = LW'(len);
    tick_in     = tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk_in);
    rst_in = 1'b1;
    wr_valid_in = 1'b0; wr_done_in = 1'b0; tick_in = 1'b0;
    wr_addr_in = '0; wr_len_in = '0;
    @(posedge clk_in);
    #1;
    check({tag, ".bank"}, int'(play_bank_out), 1);
    check({tag, ".mute"}, int'(mute_out), 1);
    check({tag, ".ready"}, int'(wr_ready_out), 1);
    check({tag, ".we"}, int'(bram_we_out), 0);
    check({tag, ".rv"}, int'(rd_valid_out), 0);
    check({tag, ".rdaddr"}, int'(bram_rd_addr_out), 0);
    check({tag, ".ur"}, int'(underrun_count_out), 0);
    check({tag, ".ovr"}, int'(overrun_count_out), 0);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  initial begin
    // Cycle table from reset: 4-word frame, bank-1 write, underrun, tick-on-swap, 3-word underrun.
    vecs[0]  = mk(0, 0, 1, 4, 0,  0, 0, 0,    0,    0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 1,  0, 0, 0, 2200,    0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 2200,    0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 2200,    0, 1, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 2200,    0, 0, 0);
    vecs[5]  = mk(1, 5, 0, 0, 0,  0, 0, 1, 2205,    0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 1,  0, 0, 0, 2200,    1, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 1,  0, 0, 0, 2200,    2, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 1,  0, 1, 0, 2200,    3, 1, 1);
    vecs[9]  = mk(0, 0, 0, 0, 1,  0, 1, 0, 2200,    3, 1, 1);
    vecs[10] = mk(0, 0, 0, 0, 0,  0, 1, 0, 2200,    3, 1, 1);
    vecs[11] = mk(0, 0, 0, 0, 0,  0, 1, 0, 2200,    3, 0, 1);
    vecs[12] = mk(0, 0, 1, 3, 1,  1, 0, 0, 2200,    3, 0, 1);
    vecs[13] = mk(0, 0, 0, 0, 1,  1, 0, 0,    0, 2200, 0, 1);
    vecs[14] = mk(0, 0, 0, 0, 1,  1, 0, 0,    0, 2201, 0, 1);
    vecs[15] = mk(0, 0, 0, 0, 1,  1, 1, 0,    0, 2202, 1, 2);
    vecs[16] = mk(0, 0, 0, 0, 1,  1, 1, 0,    0, 2202, 1, 2);
    vecs[17] = mk(0, 0, 0, 0, 0,  1, 1, 0,    0, 2202, 1, 2);
    vecs[18] = mk(0, 0, 0, 0, 0,  1, 1, 0,    0, 2202, 0, 2);

    do_reset("rst0");
`ifndef OUTBUF_REPEAT_EN
    for (int i = 0; i < 19; i++) begin
      step(vecs[i].wv, vecs[i].wa, vecs[i].done, vecs[i].len, vecs[i].tick);
      check($sformatf("v%0d.bank", i), int'(play_bank_out), int'(vecs[i].bank));
      check($sformatf("v%0d.mute", i), int'(mute_out), int'(vecs[i].mute));
      check($sformatf("v%0d.ready", i), int'(wr_ready_out), int'(vecs[i].ready));
      check($sformatf("v%0d.we", i), int'(bram_we_out), int'(vecs[i].we));
      check($sformatf("v%0d.wraddr", i), int'(bram_wr_addr_out), vecs[i].wao);
      check($sformatf("v%0d.rdaddr", i), int'(bram_rd_addr_out), vecs[i].rao);
      check($sformatf("v%0d.rv", i), int'(rd_valid_out), int'(vecs[i].rv));
      check($sformatf("v%0d.ur", i), int'(underrun_count_out), vecs[i].ur);
      check($sformatf("v%0d.ovr", i), int'(overrun_count_out), vecs[i].ovr);
    end
`endif

    // Overrun: 10-word frame playing, two done pulses (10 then 20) before it ends.
    do_reset("rst1");
    step(0, 0, 1, 10, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1);
    step(0, 0, 1, 10, 0);
    check("ovr.first_ready", int'(wr_ready_out), 0);
    check("ovr.first_cnt", int'(overrun_count_out), 0);
    step(0, 0, 1, 20, 0);
    check("ovr.second_cnt", int'(overrun_count_out), 1);
    for (int k = 3; k < 10; k++) begin
      step(0, 0, 0, 0, 1);
      check($sformatf("ovr.rd%0d", k), int'(bram_rd_addr_out), k);
      check($sformatf("ovr.ready%0d", k), int'(wr_ready_out), (k == 9) ? 1 : 0);
      check($sformatf("ovr.bank%0d", k), int'(play_bank_out), (k == 9) ? 1 : 0);
    end
    for (int j = 0; j < 20; j++) begin
      step(0, 0, 0, 0, 1);
      check($sformatf("ovr.f2rd%0d", j), int'(bram_rd_addr_out), 2200 + j);
      check($sformatf("ovr.f2mute%0d", j), int'(mute_out), (j == 19) ? 1 : 0);
    end
    check("ovr.ur", int'(underrun_count_out), 1);
    check("ovr.final_cnt", int'(overrun_count_out), 1);

    // Done pulse on the exact end-of-frame tick swaps directly.
    do_reset("rst2");
    step(0, 0, 1, 2, 0);
    step(0, 0, 0, 0, 1);
    check("sim.rd0", int'(bram_rd_addr_out), 0);
    step(0, 0, 1, 5, 1);
    check("sim.bank", int'(play_bank_out), 1);
    check("sim.mute", int'(mute_out), 0);
    check("sim.ur", int'(underrun_count_out), 0);
    check("sim.ovr", int'(overrun_count_out), 0);
    check("sim.ready", int'(wr_ready_out), 1);
    step(0, 0, 0, 0, 1);
    check("sim.newbase", int'(bram_rd_addr_out), 2200);

    // 2-word frame, 5 ticks: replay or underrun depending on build.
    do_reset("rst3");
    step(0, 0, 1, 2, 0);
    for (int t = 0; t < 5; t++) begin
      step(0, 0, 0, 0, 1);
`ifdef OUTBUF_REPEAT_EN
      check($sformatf("rep.rd%0d", t), int'(bram_rd_addr_out), t % 2);
      check($sformatf("rep.mute%0d", t), int'(mute_out), 0);
`else
      check($sformatf("rep.rd%0d", t), int'(bram_rd_addr_out), (t == 0) ? 0 : 1);
      check($sformatf("rep.mute%0d", t), int'(mute_out), (t == 0) ? 0 : 1);
`endif
    end
`ifdef OUTBUF_REPEAT_EN
    check("rep.ur", int'(underrun_count_out), 2);
`else
    check("rep.ur", int'(underrun_count_out), 1);
`endif

    // Reset mid-frame returns everything to power-up values.
    step(0, 0, 1, 7, 0);
    step(0, 0, 0, 0, 1);
    do_reset("rst4");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
